// File: rtl/pbit_rng_if.sv
// pbit_rng_if
//   Handshake bundle between the p-bit update array and the shared RNG arbiter.
//   master : p-bit array side (drives req / reseed_req, consumes grants and words)
//   slave  : arbiter side
//   Signals:
//     req        NREQ  level request per p-bit unit
//     reseed_req 1     single-cycle pulse: reload LFSR seed and re-warm
//     gnt        NREQ  one-hot grant pulse, registered
//     rnd_out    32    random word for the granted unit, valid while |gnt
//     ready      1     high while the arbiter is serving words
interface pbit_rng_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic            reseed_req;
    logic [NREQ-1:0] gnt;
    logic [31:0]     rnd_out;
    logic            ready;

    modport master (output req, reseed_req, input gnt, rnd_out, ready);
    modport slave  (input req, reseed_req, output gnt, rnd_out, ready);
endinterface

// File: rtl/pbit_rng_arbiter.sv
// pbit_rng_arbiter
//   Shares one 32-bit LFSR among NREQ p-bit update units. Holds the LFSR in
//   seed-load for RESEED_CYC cycles, discards WARMUP steps, then hands out one
//   fresh word per grant, round-robin across requesters.
//   Ports:
//     clk          clock
//     reset_n      asynchronous active-low reset
//     bus          pbit_rng_if slave: req, reseed_req in; gnt, rnd_out, ready out
//     lfsr_q_i     current LFSR state word
//     lfsr_ce_o    LFSR step enable (steps at the edge ending a cycle with ce=1)
//     lfsr_rst_n_o LFSR seed-load, active-low, registered
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_RESEED | LFSR held in seed-load for RESEED_CYC cycles, no grants
//   S_WARMUP | LFSR free-runs WARMUP steps, outputs discarded
//   S_SERVE  | one grant + word per cycle while any req is high
module pbit_rng_arbiter #(
    parameter int NREQ       = 4,
    parameter int WARMUP     = 64,
    parameter int RESEED_CYC = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    pbit_rng_if.slave   bus,
    input  logic [31:0] lfsr_q_i,
    output logic        lfsr_ce_o,
    output logic        lfsr_rst_n_o
);
    localparam int CNT_MAX = (WARMUP > RESEED_CYC) ? WARMUP : RESEED_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(NREQ);

    localparam logic [CW-1:0]   RESEED_LAST = CW'(RESEED_CYC - 1);
    localparam logic [CW-1:0]   WARM_LAST   = (WARMUP > 0) ? CW'(WARMUP - 1) : '0;
    localparam logic [NREQ-1:0] ONE_HOT0    = NREQ'(1);

    typedef enum logic [1:0] {S_RESEED, S_WARMUP, S_SERVE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   rr_ptr_d;
    logic [PW-1:0]   pick;
    logic            found;
    int              idx;
    logic [NREQ-1:0] gnt_q;
    logic [31:0]     rnd_out_q;
    logic            ready_q;
    logic            lfsr_rst_n_q;
    logic            any_req;

    assign any_req      = |bus.req;
    assign bus.gnt      = gnt_q;
    assign bus.rnd_out  = rnd_out_q;
    assign bus.ready    = ready_q;
    assign lfsr_rst_n_o = lfsr_rst_n_q;

    // Stepping on every served edge guarantees each granted word is fresh.
    assign lfsr_ce_o = (state_q == S_WARMUP) || ((state_q == S_SERVE) && any_req);

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
        rr_ptr_d = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_RESEED;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            rnd_out_q    <= '0;
            ready_q      <= 1'b0;
            lfsr_rst_n_q <= 1'b0;
        end else begin
            gnt_q <= '0;
            case (state_q)
                S_RESEED: begin
                    if (cnt_q == RESEED_LAST) begin
                        cnt_q        <= '0;
                        lfsr_rst_n_q <= 1'b1;
                        if (WARMUP == 0) begin
                            state_q <= S_SERVE;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= S_WARMUP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WARMUP: begin
                    if (bus.reseed_req) begin
                        state_q      <= S_RESEED;
                        cnt_q        <= '0;
                        lfsr_rst_n_q <= 1'b0;
                    end else if (cnt_q == WARM_LAST) begin
                        state_q <= S_SERVE;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SERVE: begin
                    // Reseed takes priority over a same-cycle request.
                    if (bus.reseed_req) begin
                        state_q      <= S_RESEED;
                        cnt_q        <= '0;
                        ready_q      <= 1'b0;
                        lfsr_rst_n_q <= 1'b0;
                    end else if (any_req) begin
                        gnt_q     <= ONE_HOT0 << pick;
                        rnd_out_q <= lfsr_q_i;
                        rr_ptr_q  <= rr_ptr_d;
                    end
                end
                default: begin
                    state_q      <= S_RESEED;
                    cnt_q        <= '0;
                    ready_q      <= 1'b0;
                    lfsr_rst_n_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pbit_rng_arbiter.sv
// tb_pbit_rng_arbiter
//   Drives pbit_rng_arbiter with a bench-side LFSR, checks every cycle against a
//   phase/step-count model, and pins the model with directed literal checks.
module tb_pbit_rng_arbiter;
    localparam int NREQ = 4;
    localparam int WARMUP = 64;
    localparam int RESEED_CYC = 2;
    localparam logic [31:0] SEED = 32'hACE1_1234;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] lfsr_q;
    logic        lfsr_ce;
    logic        lfsr_rst_n;

    pbit_rng_if #(.NREQ(NREQ)) bus ();

    pbit_rng_arbiter #(.NREQ(NREQ), .WARMUP(WARMUP), .RESEED_CYC(RESEED_CYC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .lfsr_q_i     (lfsr_q),
        .lfsr_ce_o    (lfsr_ce),
        .lfsr_rst_n_o (lfsr_rst_n)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'hB4BC_D35C : 32'h0);
    endfunction

    function automatic logic [31:0] lfsr_after(input int steps);
        logic [31:0] x;
        x = SEED;
        for (int s = 0; s < steps; s++) x = lfsr_next(x);
        return x;
    endfunction

    // LFSR instance the arbiter sequences (stimulus, not model).
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)         lfsr_q <= SEED;
        else if (!lfsr_rst_n) lfsr_q <= SEED;
        else if (lfsr_ce)     lfsr_q <= lfsr_next(lfsr_q);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 reseed, 1 warm-up, 2 serve; words indexed by LFSR steps since seed.
    int              m_phase, m_cnt, m_ptr, m_steps;
    logic [NREQ-1:0] m_gnt;
    logic [31:0]     m_rnd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_cnt = 0; m_ptr = 0; m_steps = 0; m_gnt = '0; m_rnd = '0;
        end else begin
            m_gnt = '0;
            if (m_phase == 0) begin
                m_cnt++;
                if (m_cnt == RESEED_CYC) begin
                    m_cnt = 0; m_steps = 0;
                    m_phase = (WARMUP > 0) ? 1 : 2;
                end
            end else if (bus.reseed_req) begin
                m_phase = 0; m_cnt = 0;
            end else if (m_phase == 1) begin
                m_steps++; m_cnt++;
                if (m_cnt == WARMUP) begin m_cnt = 0; m_phase = 2; end
            end else if (bus.req != 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (m_gnt == 0 && bus.req[(m_ptr + i) % NREQ]) begin
                        m_gnt[(m_ptr + i) % NREQ] = 1'b1;
                        m_ptr = (m_ptr + i + 1) % NREQ;
                    end
                end
                m_rnd = lfsr_after(m_steps);
                m_steps++;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("gnt", bus.gnt, m_gnt);
            chk("rnd_out", bus.rnd_out, m_rnd);
            chk("ready", bus.ready, m_phase == 2);
            chk("lfsr_rst_n", lfsr_rst_n, m_phase != 0);
            chk("lfsr_ce", lfsr_ce, (m_phase == 1) || (m_phase == 2 && bus.req != 0));
            if (m_phase != 0) chk("lfsr_q", lfsr_q, lfsr_after(m_steps));
        end
    end

    logic [31:0] words[8];
    logic [31:0] first_word, w, frozen;
    logic [NREQ-1:0] g;

    // From reset release: seed-load 2 cycles, 64 warm-up steps, ready in cycle 67.
    task automatic powerup(input string tag);
        int first_rst, first_rdy, ce_cnt, gnt_seen;
        first_rst = 0; first_rdy = 0; ce_cnt = 0; gnt_seen = 0;
        for (int n = 1; n <= 100 && first_rdy == 0; n++) begin
            @(negedge clk);
            if (lfsr_rst_n && first_rst == 0) first_rst = n;
            if (lfsr_ce) ce_cnt++;
            if (bus.ready && first_rdy == 0) first_rdy = n;
            if (bus.gnt != 0) gnt_seen = 1;
        end
        chk({tag, "_rst_rise_cycle"}, first_rst, 3);
        chk({tag, "_ready_cycle"}, first_rdy, 67);
        chk({tag, "_ce_cycles"}, ce_cnt, 64);
        chk({tag, "_no_gnt"}, gnt_seen, 0);
    endtask

    initial begin
        int distinct, low, got;
        reset_n = 1'b0;
        bus.req = '0;
        bus.reseed_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_lfsr_rst_n", lfsr_rst_n, 0);
        #1 reset_n = 1'b1;

        powerup("t1");

        // Round-robin across all four, each word equal to lfsr_q at its grant edge.
        @(posedge clk); #2 bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); w = lfsr_q;
            @(posedge clk); #1;
            chk("t2_gnt", bus.gnt, 4'b0001 << (k % 4));
            chk("t2_word", bus.rnd_out, w);
            words[k] = bus.rnd_out;
        end
        first_word = words[0];
        chk("t2_first_word", first_word, lfsr_after(64));
        distinct = 1;
        for (int a = 0; a < 8; a++)
            for (int b = a + 1; b < 8; b++)
                if (words[a] == words[b]) distinct = 0;
        chk("t2_distinct", distinct, 1);

        // Sole requester gets a word every cycle; LFSR freezes when it drops.
        bus.req = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 chk("t3_gnt", bus.gnt, 4'b0100);
        end
        bus.req = '0;
        #1 chk("t3_ce_drop", lfsr_ce, 0);
        frozen = lfsr_q;
        repeat (3) @(posedge clk);
        #1 chk("t3_frozen", lfsr_q, frozen);

        // Pointer: unit 1 then ptr=2; 1010 -> unit 3, wrap, unit 1.
        bus.req = 4'b0010;
        @(posedge clk); #1 chk("t4_setup", bus.gnt, 4'b0010);
        bus.req = 4'b1010;
        @(posedge clk); #1 chk("t4_gnt_a", bus.gnt, 4'b1000);
        @(posedge clk); #1 chk("t4_gnt_b", bus.gnt, 4'b0010);
        bus.req = '0;

        // Reseed with requests pending: reseed wins, sequence replays from seed.
        @(posedge clk); #1 begin bus.req = 4'b1111; bus.reseed_req = 1'b1; end
        @(posedge clk); #1;
        chk("t5_no_gnt", bus.gnt, 0);
        chk("t5_rst_low", lfsr_rst_n, 0);
        bus.reseed_req = 1'b0;
        low = 0; got = 0; g = '0; w = '0;
        for (int n = 0; n < 200 && got == 0; n++) begin
            @(negedge clk);
            if (!lfsr_rst_n) low++;
            if (bus.gnt != 0) begin got = 1; w = bus.rnd_out; g = bus.gnt; end
        end
        chk("t5_grant_seen", got, 1);
        chk("t5_rst_low_cycles", low, 2);
        chk("t5_first_gnt", g, 4'b0100);
        chk("t5_replay_word", w, first_word);
        bus.req = '0;

        // Async reset during warm-up cycle 30, then full sequence again.
        @(posedge clk); #1 bus.reseed_req = 1'b1;
        @(posedge clk); #1 bus.reseed_req = 1'b0;
        repeat (RESEED_CYC + 29) @(posedge clk);
        #1 chk("t6_in_warmup", lfsr_ce, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_gnt", bus.gnt, 0);
        chk("t6_rnd", bus.rnd_out, 0);
        chk("t6_ready", bus.ready, 0);
        chk("t6_lfsr_rst_n", lfsr_rst_n, 0);
        chk("t6_lfsr_ce", lfsr_ce, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        powerup("t6");
        @(posedge clk); #1 bus.req = 4'b0011;
        @(posedge clk); #1;
        chk("t6_ptr_reset", bus.gnt, 4'b0001);
        chk("t6_word", bus.rnd_out, first_word);
        bus.req = '0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
